// File: rtl/button_event_arbiter_if.sv
// Event handshake between the button front end (master) and the processor (slave).
// One event ID is offered at a time and held until it is acknowledged.
interface button_event_arbiter_if #(
  parameter int ID_W = 2
);
  logic            event_valid;
  logic [ID_W-1:0] event_id;
  logic            event_ack;

  modport master (
    output event_valid,
    output event_id,
    input  event_ack
  );

  modport slave (
    input  event_valid,
    input  event_id,
    output event_ack
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Push-button front end: synchronizes active-low buttons, applies per-channel lockout,
// queues one pending event per channel and serves them round-robin over a valid/ack handshake.
module button_event_arbiter #(
  parameter int NUM_BUTTONS    = 4,
  parameter int ID_W           = 2,
  parameter int LOCKOUT_CYCLES = 15000000,
  parameter int CNT_W          = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttonNotPressed,
  button_event_arbiter_if.master evt,
  output logic [NUM_BUTTONS-1:0] busy,
  output logic                   overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } state_t;

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_BUTTONS-1:0] pending_q, pending_d;
  logic [NUM_BUTTONS-1:0] press, clr, ovf_hit, busy_w;
  logic                   overflow_q, overflow_d;
  state_t                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [ID_W-1:0]        last_grant_q, last_grant_d;
  logic [ID_W-1:0]        grant_idx, rr_idx;
  logic                   grant_found, grant_fire;

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign press[gi]   = sync2_q[gi] & ~prev_q[gi] & ~busy_q;
    assign clr[gi]     = grant_fire && (grant_idx == ID_W'(gi));
    // A new press beats a same-cycle grant clear, and is not an overflow in that case.
    assign pending_d[gi] = press[gi] | (pending_q[gi] & ~clr[gi]);
    assign ovf_hit[gi]   = press[gi] & pending_q[gi] & ~clr[gi];
    assign busy_w[gi]    = busy_q;

    always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (press[gi]) begin
        busy_d = 1'b1;
        cnt_d  = '0;
      end else if (busy_q) begin
        if (cnt_q == CNT_MAX) begin
          if (!sync2_q[gi]) busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        busy_q <= busy_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = '0;
    for (int k = 1; k <= NUM_BUTTONS; k++) begin
      rr_idx = ID_W'((int'(last_grant_q) + k) % NUM_BUTTONS);
      if (!grant_found && pending_q[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    grant_fire   = 1'b0;
    overflow_d   = overflow_q | (|ovf_hit);
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          grant_fire = 1'b1;
          id_d       = grant_idx;
          valid_d    = 1'b1;
          state_d    = S_OFFER;
        end
      end
      S_OFFER: begin
        if (evt.event_ack) begin
          valid_d      = 1'b0;
          last_grant_d = id_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      overflow_q   <= 1'b0;
      state_q      <= S_IDLE;
      valid_q      <= 1'b0;
      id_q         <= '0;
      last_grant_q <= ID_W'(NUM_BUTTONS - 1);
    end else begin
      sync1_q      <= ~buttonNotPressed;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      valid_q      <= valid_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign evt.event_valid = valid_q;
  assign evt.event_id    = id_q;
  assign busy            = busy_w;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed and scoreboarded checks of button_event_arbiter with a short lockout (8 cycles).
module tb_button_event_arbiter;
  localparam int NB   = 4;
  localparam int IDW  = 2;
  localparam int LOCK = 8;
  localparam int CW   = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_n = '1;
  logic [NB-1:0] busy;
  logic          overflow;

  button_event_arbiter_if #(.ID_W(IDW)) evt ();

  button_event_arbiter #(
    .NUM_BUTTONS   (NB),
    .ID_W          (IDW),
    .LOCKOUT_CYCLES(LOCK),
    .CNT_W         (CW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .buttonNotPressed(btn_n),
    .evt             (evt),
    .busy            (busy),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_ids[$];
  int ev_cnt[NB];

  typedef struct {
    logic [NB-1:0]  btn_n;
    logic           ack;
    logic           exp_valid;
    logic [IDW-1:0] exp_id;
    logic [NB-1:0]  exp_busy;
    logic           exp_ovf;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n, input bit auto_ack);
    for (int i = 0; i < n; i++) begin
      tick();
      evt.event_ack = auto_ack && evt.event_valid && !evt.event_ack;
    end
  endtask

  task automatic clear_events();
    ev_ids.delete();
    for (int i = 0; i < NB; i++) ev_cnt[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    evt.event_ack = 1'b0;
    tick();
    check("rst_valid", 32'(evt.event_valid), 0);
    check("rst_id", 32'(evt.event_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    clear_events();
  endtask

  task automatic check_events(input string nm, input int n, input int e0, input int e1,
                              input int e2, input int e3);
    int exp_ids[4];
    exp_ids = '{e0, e1, e2, e3};
    check({nm, "_count"}, 32'(ev_ids.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check({nm, "_id"}, (i < ev_ids.size()) ? 32'(ev_ids[i]) : 32'hFFFF_FFFF, 32'(exp_ids[i]));
  endtask

  // Handshake monitor: logs each offered event and checks it is held stable until acked.
  logic           pv = 1'b0;
  logic           pa = 1'b0;
  logic [IDW-1:0] pid = '0;
  always @(negedge clock) begin
    if (pv && !pa && evt.event_valid)
      check("id_stable", 32'(evt.event_id), 32'(pid));
    if (pv && pa)
      check("valid_drop_after_ack", 32'(evt.event_valid), 0);
    if (evt.event_valid && !pv) begin
      ev_ids.push_back(int'(evt.event_id));
      ev_cnt[evt.event_id] = ev_cnt[evt.event_id] + 1;
      $display("event offered id=%0d t=%0t", evt.event_id, $time);
    end
    pv  <= evt.event_valid;
    pa  <= evt.event_ack;
    pid <= evt.event_id;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pressed[NB];
    int cool[NB];
    int hold[NB];
    int delay;

    // Row r drives its inputs, then outputs are compared after the following edge.
    tbl[0]  = '{4'b1011, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1011, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[2]  = '{4'b1011, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0};
    tbl[3]  = '{4'b1011, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0};
    tbl[4]  = '{4'b1011, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b0};
    tbl[5]  = '{4'b1011, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0};
    tbl[6]  = '{4'b1011, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0};
    tbl[7]  = '{4'b1011, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0};
    tbl[8]  = '{4'b1011, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0};
    tbl[9]  = '{4'b1011, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0};
    tbl[10] = '{4'b1011, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0};
    tbl[11] = '{4'b1011, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0};
    tbl[12] = '{4'b1111, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0};
    tbl[13] = '{4'b1111, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0};
    tbl[14] = '{4'b1111, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};
    tbl[15] = '{4'b1111, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};

    evt.event_ack = 1'b0;

    // Test 1: latency, single event while held, lockout release.
    do_reset();
    for (int r = 0; r < 16; r++) begin
      btn_n         = tbl[r].btn_n;
      evt.event_ack = tbl[r].ack;
      tick();
      $display("row %0d: valid=%0b id=%0d busy=%b ovf=%0b", r, evt.event_valid,
               evt.event_id, busy, overflow);
      check("t1_valid", 32'(evt.event_valid), 32'(tbl[r].exp_valid));
      check("t1_id", 32'(evt.event_id), 32'(tbl[r].exp_id));
      check("t1_busy", 32'(busy), 32'(tbl[r].exp_busy));
      check("t1_ovf", 32'(overflow), 32'(tbl[r].exp_ovf));
    end
    evt.event_ack = 1'b0;
    check_events("t1_events", 1, 2, 0, 0, 0);

    // Test 2: bouncing button gives a single event.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      btn_n[1] = ((c / 2) % 2) != 0;
      run(1, 1'b1);
    end
    btn_n[1] = 1'b0;
    run(20, 1'b1);
    btn_n[1] = 1'b1;
    run(12, 1'b1);
    check_events("t2_events", 1, 1, 0, 0, 0);
    check("t2_ovf", 32'(overflow), 0);
    check("t2_busy", 32'(busy), 0);

    // Test 3: simultaneous presses served round-robin, then a later btn0 press.
    do_reset();
    btn_n = 4'b0100;
    run(2, 1'b1);
    btn_n = 4'b1111;
    run(14, 1'b1);
    btn_n = 4'b1110;
    run(2, 1'b1);
    btn_n = 4'b1111;
    run(20, 1'b1);
    check_events("t3_events", 4, 0, 1, 3, 0);
    check("t3_ovf", 32'(overflow), 0);

    // Test 4: unacked offer; second press queues, third press overflows.
    do_reset();
    btn_n = 4'b1011;
    run(3, 1'b0);
    btn_n = 4'b1111;
    run(12, 1'b0);
    check("t4_valid1", 32'(evt.event_valid), 1);
    check("t4_id1", 32'(evt.event_id), 2);
    check("t4_ovf1", 32'(overflow), 0);
    btn_n = 4'b1011;
    run(3, 1'b0);
    btn_n = 4'b1111;
    run(12, 1'b0);
    check("t4_ovf2", 32'(overflow), 0);
    check("t4_valid2", 32'(evt.event_valid), 1);
    btn_n = 4'b1011;
    run(3, 1'b0);
    btn_n = 4'b1111;
    run(6, 1'b0);
    check("t4_ovf3", 32'(overflow), 1);
    check("t4_busy3", 32'(busy), 32'(4'b0100));
    run(20, 1'b1);
    check_events("t4_events", 2, 2, 2, 0, 0);
    check("t4_ovf_sticky", 32'(overflow), 1);
    check("t4_idle", 32'(evt.event_valid), 0);

    // Test 5: reset mid-offer with events pending; held buttons re-report afterwards.
    clear_events();
    btn_n = 4'b0100;
    run(4, 1'b0);
    check("t5_valid_pre", 32'(evt.event_valid), 1);
    check("t5_id_pre", 32'(evt.event_id), 3);
    do_reset();
    run(20, 1'b1);
    check_events("t5_events", 3, 0, 1, 3, 0);
    check("t5_ovf", 32'(overflow), 0);
    btn_n = 4'b1111;
    run(12, 1'b1);

    // Test 6: random presses and ack delays; every press must yield one event.
    do_reset();
    delay = int'($urandom_range(0, 5));
    for (int ch = 0; ch < NB; ch++) begin
      pressed[ch] = 0;
      cool[ch]    = 0;
      hold[ch]    = 0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      tick();
      if (evt.event_ack) begin
        evt.event_ack = 1'b0;
        delay = int'($urandom_range(0, 5));
      end else if (evt.event_valid) begin
        if (delay == 0) evt.event_ack = 1'b1;
        else delay--;
      end
      for (int ch = 0; ch < NB; ch++) begin
        if (hold[ch] > 0) begin
          hold[ch]--;
          if (hold[ch] == 0) begin
            btn_n[ch[1:0]] = 1'b1;
            cool[ch] = 12;
          end
        end else if (cool[ch] > 0) begin
          cool[ch]--;
        end else if (cyc < 700 && pressed[ch] == ev_cnt[ch] && $urandom_range(0, 7) == 0) begin
          btn_n[ch[1:0]] = 1'b0;
          hold[ch] = int'($urandom_range(1, 4));
          pressed[ch]++;
          $display("random press ch=%0d hold=%0d t=%0t", ch, hold[ch], $time);
        end
      end
    end
    btn_n = 4'b1111;
    run(40, 1'b1);
    for (int ch = 0; ch < NB; ch++)
      check("t6_events_per_channel", 32'(ev_cnt[ch]), 32'(pressed[ch]));
    check("t6_ovf", 32'(overflow), 0);
    check("t6_valid_end", 32'(evt.event_valid), 0);
    check("t6_busy_end", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
